// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared types and limits for the control-transfer flush controller
package branch_ctrl_pkg;
  typedef enum logic [1:0] {CTL_BR = 2'b00, CTL_JAL = 2'b01, CTL_JALR = 2'b10} ctl_kind_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REDIRECT, S_DRAIN} bfc_state_e;
  localparam int CTL_LAT_MAX = 15;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstB,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  // hold at all-ones once reached
  always_comb count_d = (inc && count_q != {W{1'b1}}) ? count_q + 1'b1 : count_q;
  // count register
  always_ff @(posedge clk or negedge rstB)
    if (!rstB) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/branch_flush_ctrl.sv
// branch_flush_ctrl: holds fetch until a control transfer resolves, then redirects and flushes
module branch_flush_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int RESOLVE_LAT = 2,
  parameter int DRAIN_CYC   = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstB,
  input  logic             stall,
  input  logic             ctl_valid,
  input  logic [1:0]       ctl_kind,
  input  logic             jmp_occur,
  output logic             pc_load,
  output logic             fetch_hold,
  output logic             flush_if,
  output logic             flush_id,
  output logic             ctl_busy,
  output logic [CNT_W-1:0] ctl_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             proto_err
);
  if (RESOLVE_LAT < 1 || RESOLVE_LAT > CTL_LAT_MAX) begin : g_bad_lat
    $error("RESOLVE_LAT out of range");
  end
  if (DRAIN_CYC < 0 || DRAIN_CYC > CTL_LAT_MAX) begin : g_bad_drain
    $error("DRAIN_CYC out of range");
  end
  localparam logic [3:0] LAT_INIT   = 4'(RESOLVE_LAT - 1);
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC - 1);
  bfc_state_e state_q, state_d;
  logic [3:0] lat_q, lat_d, drain_q, drain_d;
  logic       jump_q, jump_d, err_q, err_d;
  logic       accept;
  assign accept     = state_q == S_IDLE && ctl_valid && !stall;
  assign ctl_busy   = state_q != S_IDLE;
  assign fetch_hold = state_q == S_WAIT || state_q == S_REDIRECT;
  assign flush_if   = state_q == S_REDIRECT || state_q == S_DRAIN;
  assign flush_id   = state_q == S_REDIRECT;
  assign pc_load    = state_q == S_REDIRECT && !stall;
  assign proto_err  = err_q;
  // next-state: every move except the error flag waits for an unstalled cycle
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    drain_d = drain_q;
    jump_d  = jump_q;
    err_d   = err_q | (ctl_valid && state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_WAIT;
        lat_d   = LAT_INIT;
        jump_d  = ctl_kind == CTL_JAL || ctl_kind == CTL_JALR;
      end
      S_WAIT: if (!stall) begin
        if (lat_q != 4'd0) lat_d = lat_q - 4'd1;
        else state_d = (jump_q || jmp_occur) ? S_REDIRECT : S_IDLE;
      end
      S_REDIRECT: if (!stall) begin
        state_d = (DRAIN_CYC > 0) ? S_DRAIN : S_IDLE;
        drain_d = DRAIN_INIT;
      end
      S_DRAIN: if (!stall) begin
        if (drain_q == 4'd0) state_d = S_IDLE;
        else drain_d = drain_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state registers; reset drops any pending redirect
  always_ff @(posedge clk or negedge rstB)
    if (!rstB) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      drain_q <= '0;
      jump_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      drain_q <= drain_d;
      jump_q  <= jump_d;
      err_q   <= err_d;
    end
  sat_counter #(.W(CNT_W)) u_ctl_cnt   (.clk(clk), .rstB(rstB), .inc(accept),  .count(ctl_cnt));
  sat_counter #(.W(CNT_W)) u_taken_cnt (.clk(clk), .rstB(rstB), .inc(pc_load), .count(taken_cnt));
endmodule

// File: tb/tb_branch_flush_ctrl.sv
// tb_branch_flush_ctrl: directed and random checks against a queue-of-phases reference model
module tb_branch_flush_ctrl;
  localparam int RL = 2, DC = 1, CW = 16, SW = 4;
  localparam int P_HOLD = 0, P_SAMPLE = 1, P_REDIR = 2, P_DRAIN = 3;
  logic clk = 0, rstB = 0, stall = 0, ctl_valid = 0, jmp_occur = 0;
  logic [1:0] ctl_kind = 0;
  logic pc_load, fetch_hold, flush_if, flush_id, ctl_busy, proto_err;
  logic [CW-1:0] ctl_cnt, taken_cnt;
  logic s_pc_load, s_fetch_hold, s_flush_if, s_flush_id, s_ctl_busy, s_proto_err;
  logic [SW-1:0] s_ctl_cnt, s_taken_cnt;
  int n_chk = 0, n_fail = 0;
  int q[$];
  bit m_jump = 0, m_err = 0;
  int m_ctl = 0, m_taken = 0;
  logic [5:0] o;

  branch_flush_ctrl #(.RESOLVE_LAT(RL), .DRAIN_CYC(DC), .CNT_W(CW)) dut (
    .clk(clk), .rstB(rstB), .stall(stall), .ctl_valid(ctl_valid), .ctl_kind(ctl_kind),
    .jmp_occur(jmp_occur), .pc_load(pc_load), .fetch_hold(fetch_hold), .flush_if(flush_if),
    .flush_id(flush_id), .ctl_busy(ctl_busy), .ctl_cnt(ctl_cnt), .taken_cnt(taken_cnt),
    .proto_err(proto_err));
  branch_flush_ctrl #(.RESOLVE_LAT(RL), .DRAIN_CYC(DC), .CNT_W(SW)) dut_s (
    .clk(clk), .rstB(rstB), .stall(stall), .ctl_valid(ctl_valid), .ctl_kind(ctl_kind),
    .jmp_occur(jmp_occur), .pc_load(s_pc_load), .fetch_hold(s_fetch_hold), .flush_if(s_flush_if),
    .flush_id(s_flush_id), .ctl_busy(s_ctl_busy), .ctl_cnt(s_ctl_cnt), .taken_cnt(s_taken_cnt),
    .proto_err(s_proto_err));

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model(output logic [5:0] obs);
    int f;
    logic [5:0] e;
    f = q.size() != 0 ? q[0] : -1;
    e = {q.size() != 0, f == P_HOLD || f == P_SAMPLE || f == P_REDIR, f == P_REDIR || f == P_DRAIN,
         f == P_REDIR, f == P_REDIR && !stall, m_err};
    obs = {ctl_busy, fetch_hold, flush_if, flush_id, pc_load, proto_err};
    chk("outs", {58'd0, obs}, {58'd0, e});
    chk("cnts", {32'd0, ctl_cnt, taken_cnt}, {32'd0, CW'(sat(m_ctl, CW)), CW'(sat(m_taken, CW))});
    chk("small", {50'd0, s_ctl_busy, s_fetch_hold, s_flush_if, s_flush_id, s_pc_load, s_proto_err,
                  s_ctl_cnt, s_taken_cnt},
        {50'd0, e, SW'(sat(m_ctl, SW)), SW'(sat(m_taken, SW))});
  endtask

  task automatic model_update();
    int f;
    if (q.size() == 0) begin
      if (ctl_valid && !stall) begin
        m_ctl++;
        m_jump = ctl_kind == 2'b01 || ctl_kind == 2'b10;
        for (int i = 0; i < RL - 1; i++) q.push_back(P_HOLD);
        q.push_back(P_SAMPLE);
      end
    end else begin
      if (ctl_valid) m_err = 1;
      if (!stall) begin
        f = q.pop_front();
        if (f == P_SAMPLE && (m_jump || jmp_occur)) begin
          q.push_back(P_REDIR);
          for (int i = 0; i < DC; i++) q.push_back(P_DRAIN);
        end
        if (f == P_REDIR) m_taken++;
      end
    end
  endtask

  task automatic step(input logic v, input logic [1:0] k, input logic j, input logic s,
                      output logic [5:0] obs);
    @(negedge clk);
    ctl_valid = v; ctl_kind = k; jmp_occur = j; stall = s;
    #1 check_model(obs);
    @(posedge clk);
    model_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstB = 0; ctl_valid = 0; stall = 0; jmp_occur = 0;
    q.delete(); m_err = 0; m_ctl = 0; m_taken = 0;
    #1 chk("reset_outs", {26'd0, pc_load, fetch_hold, flush_if, flush_id, ctl_busy, proto_err, ctl_cnt, taken_cnt}, 64'd0);
    @(negedge clk);
    rstB = 1;
  endtask

  initial begin
    #12 chk("por_outs", {26'd0, pc_load, fetch_hold, flush_if, flush_id, ctl_busy, proto_err, ctl_cnt, taken_cnt}, 64'd0);
    @(negedge clk) rstB = 1;
    step(0, 0, 0, 0, o);
    // taken branch
    step(1, 0, 0, 0, o); chk("br_T", {58'd0, o}, 64'b000000);
    step(0, 0, 0, 0, o); chk("br_T1", {58'd0, o}, 64'b110000);
    step(0, 0, 1, 0, o); chk("br_T2", {58'd0, o}, 64'b110000);
    step(0, 0, 0, 0, o); chk("br_T3", {58'd0, o}, 64'b111110);
    step(0, 0, 0, 0, o); chk("br_T4", {58'd0, o}, 64'b101000);
    step(0, 0, 0, 0, o); chk("br_T5", {58'd0, o}, 64'b000000);
    chk("br_cnts", {32'd0, ctl_cnt, taken_cnt}, {32'd0, 16'd1, 16'd1});
    // not-taken branch
    step(1, 0, 0, 0, o);
    step(0, 0, 0, 0, o);
    step(0, 0, 0, 0, o); chk("nt_T2", {58'd0, o}, 64'b110000);
    step(0, 0, 0, 0, o); chk("nt_T3", {58'd0, o}, 64'b000000);
    chk("nt_cnts", {32'd0, ctl_cnt, taken_cnt}, {32'd0, 16'd2, 16'd1});
    // jalr ignores jmp_occur
    step(1, 2, 0, 0, o);
    step(0, 0, 0, 0, o);
    step(0, 0, 0, 0, o);
    step(0, 0, 0, 0, o); chk("jalr_T3", {58'd0, o}, 64'b111110);
    step(0, 0, 0, 0, o);
    step(0, 0, 0, 0, o);
    chk("jalr_cnts", {32'd0, ctl_cnt, taken_cnt}, {32'd0, 16'd3, 16'd2});
    // stall around the sample cycle
    step(1, 0, 0, 0, o);
    step(0, 0, 0, 0, o);
    step(0, 0, 1, 1, o);
    step(0, 0, 1, 1, o);
    step(0, 0, 0, 1, o); chk("st_T4", {58'd0, o}, 64'b110000);
    step(0, 0, 1, 0, o);
    step(0, 0, 0, 1, o); chk("st_redir_stalled", {58'd0, o}, 64'b111100);
    step(0, 0, 0, 0, o); chk("st_redir", {58'd0, o}, 64'b111110);
    step(0, 0, 0, 0, o);
    step(0, 0, 0, 0, o); chk("st_idle", {58'd0, o}, 64'b000000);
    // ctl_valid while busy
    step(1, 0, 0, 0, o);
    step(1, 1, 0, 0, o);
    step(0, 0, 1, 0, o); chk("pe_T2", {58'd0, o}, 64'b110001);
    step(0, 0, 0, 0, o); chk("pe_T3", {58'd0, o}, 64'b111111);
    step(0, 0, 0, 0, o);
    step(0, 0, 0, 0, o); chk("pe_sticky", {58'd0, o}, 64'b000001);
    chk("pe_cnts", {32'd0, ctl_cnt, taken_cnt}, {32'd0, 16'd5, 16'd4});
    // reset while redirecting
    step(1, 0, 0, 0, o);
    step(0, 0, 0, 0, o);
    step(0, 0, 1, 0, o);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, o); chk("post_rst", {58'd0, o}, 64'd0);
    end
    // random traffic with periodic resets
    for (int c = 0; c < 2000; c++) begin
      if (c % 400 == 399) do_reset();
      step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 4) == 0, o);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
